// File: rtl/program_sequencer.sv
// Program sequencer for the 1-bit ICU: owns the program counter, streams load bytes
// into program memory and handles JMP/RTN/FLAG_O/FLAG_F with a small return stack.
module program_sequencer #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       program_write,
    input  logic       program_valid,
    input  logic [7:0] program_cmd,
    input  logic [7:0] cmd,
    input  logic       jmp,
    input  logic       rtn,
    input  logic       flag_o,
    input  logic       flag_f,
    output logic [7:0] pc,
    output logic       cpu_en,
    output logic       mem_we,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       halted,
    output logic       stack_ovf,
    output logic       load_wrap
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        JTGT,
        SKIP,
        HALT
    } state_t;

    state_t         state;
    logic [7:0]     stack_mem [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic           pw_q;
    logic           pw_rise;
    logic           stack_empty;
    logic           stack_full;
    logic           push_en;
    logic [7:0]     stack_top;

    assign pw_rise     = program_write & ~pw_q;
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign push_en     = (state == JTGT) && !pw_rise && !stack_full;

    assign cpu_en    = (state == RUN);
    assign halted    = (state == HALT);
    assign mem_we    = (state == LOAD) && program_valid;
    assign mem_wdata = program_cmd;

    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SPW'(i + 1)) stack_top = stack_mem[i];
        end
    end

    // Return addresses are pushed at the current depth slot; no reset needed on the data.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (sp == SPW'(i)) stack_mem[i] <= pc + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= '0;
            mem_waddr <= '0;
            stack_ovf <= 1'b0;
            load_wrap <= 1'b0;
            sp        <= '0;
            pw_q      <= 1'b0;
        end else begin
            pw_q <= program_write;
            case (state)
                IDLE: begin
                    if (program_write) begin
                        state     <= LOAD;
                        mem_waddr <= '0;
                    end else begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                LOAD: begin
                    if (program_valid) begin
                        mem_waddr <= mem_waddr + 8'd1;
                        if (mem_waddr == 8'hFF) load_wrap <= 1'b1;
                    end
                    if (!program_write) begin
                        state <= RUN;
                        pc    <= '0;
                        sp    <= '0;
                    end
                end
                default: begin
                    // A fresh load request overrides whatever the ICU is doing.
                    if (pw_rise) begin
                        state     <= LOAD;
                        sp        <= '0;
                        mem_waddr <= '0;
                    end else begin
                        case (state)
                            RUN: begin
                                if (flag_f) begin
                                    state <= HALT;
                                end else if (rtn) begin
                                    if (!stack_empty) begin
                                        pc    <= stack_top;
                                        sp    <= sp - SPW'(1);
                                        state <= SKIP;
                                    end else begin
                                        pc <= '0;
                                    end
                                end else if (jmp) begin
                                    pc    <= pc + 8'd1;
                                    state <= JTGT;
                                end else if (flag_o) begin
                                    pc <= '0;
                                end else begin
                                    pc <= pc + 8'd1;
                                end
                            end
                            JTGT: begin
                                if (stack_full) begin
                                    stack_ovf <= 1'b1;
                                    state     <= HALT;
                                end else begin
                                    sp    <= sp + SPW'(1);
                                    pc    <= cmd;
                                    state <= RUN;
                                end
                            end
                            SKIP: begin
                                pc    <= pc + 8'd1;
                                state <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
